gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_pkg.sv | 29 ++
 rtl/gate_sweep_cmp.sv | 28 ++
 rtl/gate_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: FSM states, sweep geometry
// and the golden truth table of the X/Y/Z gate circuit.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IDX_W       = $clog2(NUM_VECTORS);
  localparam int unsigned MISM_W      = $clog2(NUM_VECTORS + 1);
  localparam int unsigned CNT_W       = 4;

  // F = ~X*Y + Y*Z, indexed by {X,Y,Z}
  localparam logic [NUM_VECTORS-1:0] GATE_CIRCUIT_TT = 8'h8C;

  function automatic logic [MISM_W-1:0] popcount(input logic [NUM_VECTORS-1:0] v);
    logic [MISM_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      c = c + MISM_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_sweep_cmp.sv
// Compares a captured truth table against the golden one: overall pass,
// lowest mismatching vector index and mismatch count.
module gate_sweep_cmp
  import gate_sweep_pkg::*;
(
  input  logic [NUM_VECTORS-1:0] tbl,
  input  logic [NUM_VECTORS-1:0] expected,
  output logic                   pass,
  output logic [IDX_W-1:0]       err_idx,
  output logic [MISM_W-1:0]      mism_cnt
);

  logic [NUM_VECTORS-1:0] diff;

  always_comb begin
    diff     = tbl ^ expected;
    pass     = (diff == '0);
    err_idx  = '0;
    // Scan downward so the lowest differing index is the one that sticks
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (diff[i]) begin
        err_idx = IDX_W'(i);
      end
    end
    mism_cnt = popcount(diff);
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Walks the gate circuit through all eight {X,Y,Z} vectors, lets each settle,
// samples F into a truth table and grades it against a latched golden table.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_VECTORS-1:0] expected,
  input  logic                   f,
  output logic                   x,
  output logic                   y,
  output logic                   z,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] tbl,
  output logic                   pass,
  output logic [IDX_W-1:0]       err_idx,
  output logic [MISM_W-1:0]      mism_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  sweep_state_e           state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             xyz_q;
  logic [NUM_VECTORS-1:0] tbl_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic                   pass_q;
  logic [IDX_W-1:0]       err_idx_q;
  logic [MISM_W-1:0]      mism_cnt_q;

  logic [NUM_VECTORS-1:0] sample_tbl;
  logic                   cmp_pass;
  logic [IDX_W-1:0]       cmp_err_idx;
  logic [MISM_W-1:0]      cmp_mism_cnt;

  // Table as it will look once the current vector's F is captured; grading
  // the last sample's table lets pass/err_idx/mism_cnt be valid with done.
  always_comb begin
    sample_tbl        = tbl_q;
    sample_tbl[idx_q] = f;
  end

  gate_sweep_cmp u_cmp (
    .tbl      (sample_tbl),
    .expected (exp_q),
    .pass     (cmp_pass),
    .err_idx  (cmp_err_idx),
    .mism_cnt (cmp_mism_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      xyz_q      <= '0;
      tbl_q      <= '0;
      exp_q      <= '0;
      pass_q     <= 1'b0;
      err_idx_q  <= '0;
      mism_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q    <= SETTLE;
            idx_q      <= '0;
            cnt_q      <= CNT_LOAD;
            xyz_q      <= '0;
            tbl_q      <= '0;
            exp_q      <= expected;
            pass_q     <= 1'b0;
            err_idx_q  <= '0;
            mism_cnt_q <= '0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            xyz_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        SAMPLE: begin
          if (abort) begin
            state_q <= IDLE;
            xyz_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            tbl_q <= sample_tbl;
            if (idx_q == LAST_IDX) begin
              state_q    <= DONE;
              pass_q     <= cmp_pass;
              err_idx_q  <= cmp_err_idx;
              mism_cnt_q <= cmp_mism_cnt;
            end else begin
              state_q <= SETTLE;
              idx_q   <= idx_q + IDX_W'(1);
              xyz_q   <= 3'(idx_q + IDX_W'(1));
              cnt_q   <= CNT_LOAD;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {x, y, z} = xyz_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign tbl       = tbl_q;
  assign pass      = pass_q;
  assign err_idx   = err_idx_q;
  assign mism_cnt  = mism_cnt_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl driving a behavioural copy of the X/Y/Z gate circuit;
// sweep results are predicted into a scoreboard and checked when done pulses.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       f;
  logic       x, y, z, busy, done, pass;
  logic [7:0] tbl;
  logic [2:0] err_idx;
  logic [3:0] mism_cnt;

  logic       start1 = 1'b0, start15 = 1'b0, abort_alt = 1'b0;
  logic       f1, x1, y1, z1, busy1, done1, pass1;
  logic       f15, x15, y15, z15, busy15, done15, pass15;
  logic [7:0] tbl1, tbl15;
  logic [2:0] err_idx1, err_idx15;
  logic [3:0] mism_cnt1, mism_cnt15;

  int n_total = 0;
  int n_bad   = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Gate circuit under control: F = ~X*Y + Y*Z
  assign f   = (~x & y) | (y & z);
  assign f1  = (~x1 & y1) | (y1 & z1);
  assign f15 = (~x15 & y15) | (y15 & z15);

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected), .f(f),
    .x(x), .y(y), .z(z), .busy(busy), .done(done), .tbl(tbl), .pass(pass),
    .err_idx(err_idx), .mism_cnt(mism_cnt));

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort_alt), .expected(expected), .f(f1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .tbl(tbl1), .pass(pass1),
    .err_idx(err_idx1), .mism_cnt(mism_cnt1));

  gate_sweep_ctrl #(.SETTLE_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .start(start15), .abort(abort_alt), .expected(expected), .f(f15),
    .x(x15), .y(y15), .z(z15), .busy(busy15), .done(done15), .tbl(tbl15), .pass(pass15),
    .err_idx(err_idx15), .mism_cnt(mism_cnt15));

  typedef struct {
    int         done_edge;
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] err;
    logic [3:0] mism;
  } sb_t;

  typedef struct {
    logic [7:0] exp_in;
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] err;
    logic [3:0] mism;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic sb_push(input int de, input logic [7:0] t, input logic p,
                         input logic [2:0] e, input logic [3:0] m);
    sb_t r;
    r.done_edge = de; r.tbl = t; r.pass = p; r.err = e; r.mism = m;
    sb_q.push_back(r);
  endtask

  task automatic wait_sb_empty(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("sb_drain_timeout", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
  endtask

  // Scoreboard monitor: done must appear exactly on the predicted edge
  always @(negedge clk) begin
    sb_t r;
    if (sb_q.size() != 0 && edge_n >= sb_q[0].done_edge) begin
      r = sb_q.pop_front();
      chk("done_at_cycle", 32'(done), 1);
      chk("sweep_table", 32'(tbl), 32'(r.tbl));
      chk("sweep_pass", 32'(pass), 32'(r.pass));
      chk("sweep_err_idx", 32'(err_idx), 32'(r.err));
      chk("sweep_mism_cnt", 32'(mism_cnt), 32'(r.mism));
    end else if (done) begin
      chk("stray_done", 32'(done), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int seen;

    vecs[0] = '{8'h8C, 8'h8C, 1'b1, 3'd0, 4'd0};
    vecs[1] = '{8'h8D, 8'h8C, 1'b0, 3'd0, 4'd1};
    vecs[2] = '{8'h73, 8'h8C, 1'b0, 3'd0, 4'd8};
    vecs[3] = '{8'h0C, 8'h8C, 1'b0, 3'd7, 4'd1};
    vecs[4] = '{8'h88, 8'h8C, 1'b0, 3'd2, 4'd1};
    vecs[5] = '{8'h00, 8'h8C, 1'b0, 3'd2, 4'd3};

    // Power-on reset state
    #1;
    chk("rst_xyz", 32'({x, y, z}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_table", 32'(tbl), 0);
    chk("rst_pass", 32'(pass), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps; expected is scrambled after start to prove latching
    for (int i = 0; i < 6; i++) begin
      expected = vecs[i].exp_in;
      start    = 1'b1;
      sb_push(edge_n + 1 + 24, vecs[i].tbl, vecs[i].pass, vecs[i].err, vecs[i].mism);
      @(negedge clk);
      start    = 1'b0;
      expected = ~vecs[i].exp_in;
      wait_sb_empty(40);
      @(negedge clk);
      chk("pass_held", 32'(pass), 32'(vecs[i].pass));
      chk("idle_busy", 32'(busy), 0);
    end

    // Asynchronous reset while idle with non-zero results
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idle_table", 32'(tbl), 0);
    chk("rst_idle_err_idx", 32'(err_idx), 0);
    chk("rst_idle_mism_cnt", 32'(mism_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector stepping, start ignored while busy and in DONE, re-accepted after
    expected = 8'h8C;
    e = edge_n + 1;
    for (int c = 0; c <= 52; c++) begin
      start = (c == 0 || c == 5 || c == 25 || c == 26);
      if (c == 0)  sb_push(e + 24, 8'h8C, 1'b1, 3'd0, 4'd0);
      if (c == 26) sb_push(e + 26 + 24, 8'h8C, 1'b1, 3'd0, 4'd0);
      @(negedge clk);
      if (c + 1 <= 24) chk("xyz_step", 32'({x, y, z}), 32'(c / 3));
      if (c + 1 == 25 || c + 1 == 26) chk("xyz_hold_after_last", 32'({x, y, z}), 7);
      if (c + 1 == 25) chk("busy_in_done", 32'(busy), 1);
      if (c + 1 == 26) chk("busy_after_done", 32'(busy), 0);
      if (c + 1 == 27) chk("xyz_second_sweep", 32'({x, y, z}), 0);
    end
    start = 1'b0;
    wait_sb_empty(10);

    // Abort while vector 011 is settling
    e = edge_n + 1;
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      abort = (c == 10);
      if (c == 10) chk("abort_pre_xyz", 32'({x, y, z}), 3);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_xyz", 32'({x, y, z}), 0);
    chk("abort_table", 32'(tbl), 32'h04);
    chk("abort_pass", 32'(pass), 0);
    repeat (30) @(negedge clk);

    // Abort and start together in IDLE: no sweep
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    repeat (30) @(negedge clk);

    // Abort in DONE is ignored
    e = edge_n + 1;
    sb_push(e + 24, 8'h8C, 1'b1, 3'd0, 4'd0);
    for (int c = 0; c <= 25; c++) begin
      start = (c == 0);
      abort = (c == 25);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_done_pass", 32'(pass), 1);
    chk("abort_done_table", 32'(tbl), 32'h8C);
    wait_sb_empty(5);

    // Reset mid-sweep discards it; first start after release is accepted
    e = edge_n + 1;
    sb_push(e + 24, 8'h8C, 1'b1, 3'd0, 4'd0);
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_mid_xyz", 32'({x, y, z}), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_table", 32'(tbl), 0);
    chk("rst_mid_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    sb_push(edge_n + 1 + 24, 8'h8C, 1'b1, 3'd0, 4'd0);
    @(negedge clk);
    start = 1'b0;
    wait_sb_empty(40);

    // SETTLE_CYCLES = 1
    expected = 8'h8C;
    start1 = 1'b1;
    seen = 0;
    for (int p = 1; p <= 40; p++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 && seen == 0) seen = p;
    end
    chk("sc1_done_cycle", 32'(seen), 17);
    chk("sc1_table", 32'(tbl1), 32'h8C);
    chk("sc1_pass", 32'(pass1), 1);
    chk("sc1_results", 32'({busy1, err_idx1, mism_cnt1}), 0);

    // SETTLE_CYCLES = 15
    start15 = 1'b1;
    seen = 0;
    for (int p = 1; p <= 150; p++) begin
      @(negedge clk);
      start15 = 1'b0;
      if (done15 && seen == 0) seen = p;
    end
    chk("sc15_done_cycle", 32'(seen), 129);
    chk("sc15_table", 32'(tbl15), 32'h8C);
    chk("sc15_pass", 32'(pass15), 1);
    chk("sc15_results", 32'({busy15, err_idx15, mism_cnt15}), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
